// File: rtl/snake_pkg.sv
// ---------------------------------------------------------------------------
// snake_pkg
// Purpose : shared encodings for the Snake direction controller.
//           Direction codes, reset heading, debouncer state encoding and the
//           axis-reversal helper used by the legality check.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package snake_pkg;

   localparam logic [1:0] DIR_UP    = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_LEFT  = 2'b10;
   localparam logic [1:0] DIR_RIGHT = 2'b11;
   localparam logic [1:0] DIR_INIT  = DIR_RIGHT;

   typedef enum logic [1:0] {
      DB_IDLE         = 2'd0,
      DB_WAIT_PRESS   = 2'd1,
      DB_PRESSED      = 2'd2,
      DB_WAIT_RELEASE = 2'd3
   } db_state_t;

   // Opposite headings share the axis bit and differ only in the LSB
   function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
      return ((a ^ b) == 2'b01);
   endfunction

endpackage : snake_pkg

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Purpose : two-flop synchroniser plus debouncer FSM for one raw button.
// Ports   : Clk      - system clock
//           Reset    - synchronous active-high reset
//           i_btn    - raw button, asynchronous to Clk
//           o_level  - debounced level (high from accepted press until
//                      release has been stable for DEBOUNCE_CYCLES)
//           o_pulse  - one-cycle registered pulse per accepted press
// ---------------------------------------------------------------------------
module btn_debounce
   import snake_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic Clk,
   input  logic Reset,
   input  logic i_btn,
   output logic o_level,
   output logic o_pulse
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   db_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_pulse;

   // Synchroniser and debouncer FSM; r_sync2 is the sampled button
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_state <= DB_IDLE;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_pulse <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_pulse <= 1'b0;
         case (r_state)
            DB_IDLE: begin
               if (r_sync2) begin
                  r_state <= DB_WAIT_PRESS;
                  r_cnt   <= '0;
               end
            end
            DB_WAIT_PRESS: begin
               if (!r_sync2) begin
                  r_state <= DB_IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == CNT_MAX) begin
                  r_state <= DB_PRESSED;
                  r_pulse <= 1'b1;
                  r_level <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            DB_PRESSED: begin
               if (!r_sync2) begin
                  r_state <= DB_WAIT_RELEASE;
                  r_cnt   <= '0;
               end
            end
            DB_WAIT_RELEASE: begin
               // a bounce back high returns to PRESSED without a new pulse
               if (r_sync2) begin
                  r_state <= DB_PRESSED;
               end else if (r_cnt == CNT_MAX) begin
                  r_state <= DB_IDLE;
                  r_level <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= DB_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign o_level = r_level;
   assign o_pulse = r_pulse;

endmodule : btn_debounce

// File: rtl/snake_dir_ctrl.sv
// ---------------------------------------------------------------------------
// snake_dir_ctrl
// Purpose : turns the four raw direction buttons into one validated snake
//           heading, committing at most one turn per game step tick.
// Ports   : Clk           - system clock (100 MHz)
//           Reset         - synchronous active-high reset
//           BtnU/D/L/R    - raw direction buttons
//           enable        - game FSM is in the run state
//           tick          - one-cycle game step strobe
//           dir           - committed heading (00 U, 01 D, 10 L, 11 R)
//           dir_changed   - one-cycle pulse after a tick that changed dir
//           pending_valid - an accepted turn waits for the next tick
//           btn_level     - debounced levels {U,D,L,R}
// ---------------------------------------------------------------------------
module snake_dir_ctrl
   import snake_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       BtnU,
   input  logic       BtnD,
   input  logic       BtnL,
   input  logic       BtnR,
   input  logic       enable,
   input  logic       tick,
   output logic [1:0] dir,
   output logic       dir_changed,
   output logic       pending_valid,
   output logic [3:0] btn_level
);

   logic [3:0] w_pulse;   // {U,D,L,R}
   logic [3:0] w_level;   // {U,D,L,R}
   logic       w_req_valid;
   logic [1:0] w_req;
   logic [1:0] w_ref;
   logic       w_commit;
   logic       w_accept;

   logic [1:0] r_dir;
   logic [1:0] r_pending;
   logic       r_pending_valid;
   logic       r_dir_changed;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_u (
      .Clk(Clk), .Reset(Reset), .i_btn(BtnU), .o_level(w_level[3]), .o_pulse(w_pulse[3]));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_d (
      .Clk(Clk), .Reset(Reset), .i_btn(BtnD), .o_level(w_level[2]), .o_pulse(w_pulse[2]));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_l (
      .Clk(Clk), .Reset(Reset), .i_btn(BtnL), .o_level(w_level[1]), .o_pulse(w_pulse[1]));
   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_r (
      .Clk(Clk), .Reset(Reset), .i_btn(BtnR), .o_level(w_level[0]), .o_pulse(w_pulse[0]));

   // Priority select U > D > L > R; losers are dropped
   always_comb begin
      w_req_valid = 1'b1;
      w_req       = DIR_UP;
      if (w_pulse[3])      w_req = DIR_UP;
      else if (w_pulse[2]) w_req = DIR_DOWN;
      else if (w_pulse[1]) w_req = DIR_LEFT;
      else if (w_pulse[0]) w_req = DIR_RIGHT;
      else                 w_req_valid = 1'b0;
   end

   // A turn committing this cycle becomes the heading the new request faces
   always_comb begin
      w_commit = enable & tick & r_pending_valid;
      w_ref    = w_commit ? r_pending : r_dir;
      w_accept = enable & w_req_valid & (w_req != w_ref) & ~is_opposite(w_req, w_ref);
   end

   // Pending / commit registers
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_dir           <= DIR_INIT;
         r_pending       <= DIR_INIT;
         r_pending_valid <= 1'b0;
         r_dir_changed   <= 1'b0;
      end else begin
         r_dir_changed <= 1'b0;
         if (!enable) begin
            r_pending_valid <= 1'b0;
         end else begin
            if (w_commit) begin
               r_dir           <= r_pending;
               r_dir_changed   <= 1'b1;
               r_pending_valid <= 1'b0;
            end
            if (w_accept) begin
               r_pending       <= w_req;
               r_pending_valid <= 1'b1;
            end
         end
      end
   end

   assign dir           = r_dir;
   assign dir_changed   = r_dir_changed;
   assign pending_valid = r_pending_valid;
   assign btn_level     = w_level;

endmodule : snake_dir_ctrl

// File: tb/tb_snake_dir_ctrl.sv
// ---------------------------------------------------------------------------
// tb_snake_dir_ctrl
// Purpose : self-checking bench for snake_dir_ctrl with DEBOUNCE_CYCLES=4.
// ---------------------------------------------------------------------------
module tb_snake_dir_ctrl;

   localparam int unsigned DEB = 4;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic [3:0] btn = 4'b0000;   // {U,D,L,R}
   logic       enable = 1'b1;
   logic       tick = 1'b0;
   logic [1:0] dir;
   logic       dir_changed;
   logic       pending_valid;
   logic [3:0] btn_level;

   int checks = 0;
   int failures = 0;
   int pulse_cnt [4];

   // model state for the randomized phase
   int m_dir;
   int m_pend;
   int m_pv;

   snake_dir_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut (
      .Clk(Clk), .Reset(Reset),
      .BtnU(btn[3]), .BtnD(btn[2]), .BtnL(btn[1]), .BtnR(btn[0]),
      .enable(enable), .tick(tick),
      .dir(dir), .dir_changed(dir_changed),
      .pending_valid(pending_valid), .btn_level(btn_level));

   always #5 Clk = ~Clk;

   // count internal press pulses, sampled mid-cycle
   always @(negedge Clk) begin
      for (int i = 0; i < 4; i++) if (dut.w_pulse[i]) pulse_cnt[i] = pulse_cnt[i] + 1;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0] btn;
      logic       do_tick;
      logic       exp_pv_pre;
      logic [1:0] exp_dir;
      logic       exp_pv_post;
   } vec_t;

   vec_t vecs [8];

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         failures = failures + 1;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // hold a button mask long enough to be accepted, then release and settle
   task automatic press(input logic [3:0] m);
      btn = m;
      repeat (10) step();
      btn = 4'b0000;
      repeat (10) step();
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      btn   = 4'b0000;
      step();
      Reset = 1'b0;
   endtask

   // behavioural reference: one clock edge at which a request mask may arrive
   task automatic model_edge(input bit en, input bit tk, input logic [3:0] m, output bit chg);
      int ref_h;
      int req;
      chg = 1'b0;
      if (!en) begin
         m_pv = 0;
      end else begin
         ref_h = (tk && m_pv != 0) ? m_pend : m_dir;
         if (tk && m_pv != 0) begin
            m_dir = m_pend;
            m_pv  = 0;
            chg   = 1'b1;
         end
         if (m != 4'b0000) begin
            req = -1;
            for (int b = 3; b >= 0; b--) if (req < 0 && m[b]) req = 3 - b;
            // legal only when turning onto the other axis
            if ((req / 2) != (ref_h / 2)) begin
               m_pend = req;
               m_pv   = 1;
            end
         end
      end
   endtask

   initial begin
      bit chg;
      for (int i = 0; i < 4; i++) pulse_cnt[i] = 0;

      // ---------------- reset state
      Reset = 1'b1;
      step();
      step();
      chk("reset_dir", int'(dir), 3);
      chk("reset_pv", int'(pending_valid), 0);
      chk("reset_chg", int'(dir_changed), 0);
      chk("reset_level", int'(btn_level), 0);
      Reset = 1'b0;
      step();

      // ---------------- clean press of D with latency check
      enable = 1'b1;
      btn = 4'b0100;
      repeat (7) step();
      chk("clean_pv_before_pulse", int'(pending_valid), 0);
      step();
      chk("clean_pv_after_pulse", int'(pending_valid), 1);
      repeat (12) step();
      chk("clean_pulse_count", pulse_cnt[2], 1);
      chk("clean_level_held", int'(btn_level), 4);
      btn = 4'b0000;
      repeat (10) step();
      chk("clean_level_released", int'(btn_level), 0);
      tick = 1'b1;
      step();
      tick = 1'b0;
      chk("clean_dir", int'(dir), 1);
      chk("clean_chg_high", int'(dir_changed), 1);
      step();
      chk("clean_chg_low", int'(dir_changed), 0);
      chk("clean_pv_cleared", int'(pending_valid), 0);

      // ---------------- bounce on U never reaches a press
      btn[3] = 1'b1; step();
      btn[3] = 1'b0; step();
      btn[3] = 1'b1; step();
      btn[3] = 1'b0;
      repeat (15) step();
      chk("bounce_pulses", pulse_cnt[3], 0);
      chk("bounce_level", int'(btn_level[3]), 0);
      chk("bounce_pv", int'(pending_valid), 0);

      // ---------------- table-driven turn sequence from RIGHT
      vecs[0] = '{btn: 4'b0010, do_tick: 1'b0, exp_pv_pre: 1'b0, exp_dir: 2'b11, exp_pv_post: 1'b0};
      vecs[1] = '{btn: 4'b0001, do_tick: 1'b0, exp_pv_pre: 1'b0, exp_dir: 2'b11, exp_pv_post: 1'b0};
      vecs[2] = '{btn: 4'b1000, do_tick: 1'b0, exp_pv_pre: 1'b1, exp_dir: 2'b11, exp_pv_post: 1'b1};
      vecs[3] = '{btn: 4'b0100, do_tick: 1'b1, exp_pv_pre: 1'b1, exp_dir: 2'b01, exp_pv_post: 1'b0};
      vecs[4] = '{btn: 4'b1010, do_tick: 1'b1, exp_pv_pre: 1'b0, exp_dir: 2'b01, exp_pv_post: 1'b0};
      vecs[5] = '{btn: 4'b0011, do_tick: 1'b1, exp_pv_pre: 1'b1, exp_dir: 2'b10, exp_pv_post: 1'b0};
      vecs[6] = '{btn: 4'b1000, do_tick: 1'b0, exp_pv_pre: 1'b1, exp_dir: 2'b10, exp_pv_post: 1'b1};
      vecs[7] = '{btn: 4'b0001, do_tick: 1'b1, exp_pv_pre: 1'b1, exp_dir: 2'b00, exp_pv_post: 1'b0};
      do_reset();
      for (int v = 0; v < 8; v++) begin
         press(vecs[v].btn);
         chk($sformatf("vec%0d_pv_pre", v), int'(pending_valid), int'(vecs[v].exp_pv_pre));
         if (vecs[v].do_tick) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            chk($sformatf("vec%0d_chg", v), int'(dir_changed), int'(vecs[v].exp_pv_pre));
         end
         chk($sformatf("vec%0d_dir", v), int'(dir), int'(vecs[v].exp_dir));
         chk($sformatf("vec%0d_pv_post", v), int'(pending_valid), int'(vecs[v].exp_pv_post));
      end

      // ---------------- tick coinciding with a legal pulse (dir=UP here)
      press(4'b0010);
      chk("coin_pv_left", int'(pending_valid), 1);
      btn = 4'b0100;
      repeat (7) step();
      tick = 1'b1;
      step();
      tick = 1'b0;
      chk("coin_dir", int'(dir), 2);
      chk("coin_chg", int'(dir_changed), 1);
      chk("coin_pv", int'(pending_valid), 1);
      btn = 4'b0000;
      repeat (12) step();
      tick = 1'b1;
      step();
      tick = 1'b0;
      chk("coin_dir2", int'(dir), 1);

      // ---------------- reset mid WAIT_PRESS with a pending turn
      press(4'b0010);
      chk("rst_pv_set", int'(pending_valid), 1);
      btn = 4'b0010;
      repeat (4) step();
      Reset = 1'b1;
      btn = 4'b0000;
      step();
      Reset = 1'b0;
      chk("rst_dir", int'(dir), 3);
      chk("rst_pv", int'(pending_valid), 0);
      chk("rst_level", int'(btn_level), 0);
      begin
         int before_l;
         before_l = pulse_cnt[1];
         repeat (12) step();
         chk("rst_no_pulse", pulse_cnt[1] - before_l, 0);
      end
      chk("rst_pv_later", int'(pending_valid), 0);

      // ---------------- disable clears pending, ignores press and tick
      press(4'b1000);
      chk("dis_pv_set", int'(pending_valid), 1);
      enable = 1'b0;
      step();
      chk("dis_pv_cleared", int'(pending_valid), 0);
      btn = 4'b0100;
      repeat (7) step();
      tick = 1'b1;
      step();
      tick = 1'b0;
      chk("dis_dir", int'(dir), 3);
      chk("dis_pv", int'(pending_valid), 0);
      chk("dis_chg", int'(dir_changed), 0);
      chk("dis_level", int'(btn_level), 4);
      btn = 4'b0000;
      repeat (10) step();
      enable = 1'b1;
      step();
      chk("reenable_dir", int'(dir), 3);

      // ---------------- randomized against reference model
      m_dir = 3; m_pend = 3; m_pv = 0;
      for (int it = 0; it < 60; it++) begin
         bit         en;
         logic [3:0] mask;
         int         mode;
         en   = ($urandom_range(0, 9) != 0);
         mask = 4'($urandom_range(0, 15));
         mode = $urandom_range(0, 2);
         enable = en;
         btn    = mask;
         repeat (7) step();
         tick = (mode == 1);
         step();
         tick = 1'b0;
         model_edge(en, mode == 1, mask, chg);
         chk($sformatf("rnd%0d_dir", it), int'(dir), m_dir);
         chk($sformatf("rnd%0d_pv", it), int'(pending_valid), m_pv);
         chk($sformatf("rnd%0d_chg", it), int'(dir_changed), int'(chg));
         chk($sformatf("rnd%0d_level", it), int'(btn_level), int'(mask));
         repeat (3) step();
         btn = 4'b0000;
         repeat (10) step();
         chk($sformatf("rnd%0d_level_rel", it), int'(btn_level), 0);
         if (mode == 2) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            model_edge(en, 1'b1, 4'b0000, chg);
            chk($sformatf("rnd%0d_tdir", it), int'(dir), m_dir);
            chk($sformatf("rnd%0d_tpv", it), int'(pending_valid), m_pv);
            chk($sformatf("rnd%0d_tchg", it), int'(dir_changed), int'(chg));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_snake_dir_ctrl
